// File: rtl/alu_pkg.sv
// alu_pkg -- shared types for the multi-cycle ALU.
//   alu_op_e      : 4-bit operation code; codes above OP_LAST_LEGAL are illegal
//   alu_state_e   : control FSM states
//   is_shift_op() : true for SLL/SRL/SRA
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_iter_unit -- iterative shift / shift-add multiply datapath with step counter.
//   clk, reset   : clock, async active-low reset
//   start_i      : load operands and arm the counter (shamt or WIDTH steps)
//   op_i         : SLL/SRL/SRA/MUL
//   a_i, b_i     : operands (b_i low SHW bits are the shift amount)
//   done_o       : this cycle performs the final step
//   res_o        : value produced by the step taken this cycle
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  // One extra counter bit so a full WIDTH-step multiply does not wrap.
  logic [SHW:0]       cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   acc_step;

  always_comb begin
    acc_step = acc_q;
    case (op_q)
      OP_SLL:  acc_step = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc_q[WIDTH-1:1]};
      OP_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      OP_MUL:  acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    if (start_i) begin
      run_d = 1'b1;
      op_d  = op_i;
      if (op_i == OP_MUL) begin
        acc_d   = '0;
        mcand_d = a_i;
        mplr_d  = b_i;
        cnt_d   = (SHW+1)'(WIDTH);
      end else begin
        acc_d = a_i;
        cnt_d = {1'b0, b_i[SHW-1:0]};
      end
    end else if (run_q) begin
      acc_d   = acc_step;
      mcand_d = {mcand_q[WIDTH-2:0], 1'b0};
      mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
      cnt_d   = cnt_q - (SHW+1)'(1);
      if (cnt_q == (SHW+1)'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  assign done_o = run_q && (cnt_q == (SHW+1)'(1));
  assign res_o  = acc_step;

endmodule

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with valid/ready in and out.
//   in_valid_i/in_ready_o   : request handshake (a_i, b_i, alu_op_i sampled at accept)
//   out_valid_o/out_ready_i : result handshake; result held until consumed
//   result_o, zero_o, illegal_o : registered result and flags
//   busy_o                  : request accepted, result not yet delivered
// Single-cycle ops resolve at accept; MUL and nonzero iterative shifts run
// in alu_iter_unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter int  SHIFT_ITER = 1,
  localparam int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             busy_o
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             need_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;

  assign shamt = b_i[SHW-1:0];

  // Shift by zero always takes the single-cycle path.
  assign need_iter = (alu_op_i == OP_MUL) ||
                     ((SHIFT_ITER != 0) && is_shift_op(alu_op_i) && (shamt != '0));

  always_comb begin
    sc_res = '0;
    case (alu_op_i)
      OP_ADD:  sc_res = a_i + b_i;
      OP_SUB:  sc_res = a_i - b_i;
      OP_AND:  sc_res = a_i & b_i;
      OP_OR:   sc_res = a_i | b_i;
      OP_XOR:  sc_res = a_i ^ b_i;
      OP_SLL:  sc_res = a_i << shamt;
      OP_SRL:  sc_res = a_i >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(a_i) >>> shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          illegal_d = 1'b0;
          if (need_iter) begin
            iter_start = 1'b1;
            state_d    = ST_CALC;
          end else begin
            result_d  = sc_res;
            zero_d    = (sc_res == '0);
            illegal_d = (alu_op_i > OP_LAST_LEGAL);
            state_d   = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (iter_done) begin
          result_d = iter_res;
          zero_d   = (iter_res == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (iter_start),
    .op_i    (alu_op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .done_o  (iter_done),
    .res_o   (iter_res)
  );

  assign in_ready_o  = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, illegal, busy;

  logic rand_rdy, rnd_bit, rdy_dir;
  assign out_ready = rand_rdy ? rnd_bit : rdy_dir;

  alu_mc #(.WIDTH(32), .SHIFT_ITER(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .alu_op_i(op),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero), .illegal_o(illegal), .busy_o(busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  bit   seen = 0;
  bit   chk_b2b = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin rnd_bit = 1; forever begin @(posedge clk); #2 rnd_bit = ($urandom_range(0, 3) != 0); end end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: straight from the opcode rules, with whole-word arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    int sh;
    sh = int'(y[4:0]);
    e.res = '0; e.ill = 0; e.lat = 1; e.acc = 0;
    case (o)
      4'd0:  e.res = x + y;
      4'd1:  e.res = x - y;
      4'd2:  e.res = x & y;
      4'd3:  e.res = x | y;
      4'd4:  e.res = x ^ y;
      4'd5:  e.res = x << sh;
      4'd6:  e.res = x >> sh;
      4'd7:  e.res = 32'($signed(x) >>> sh);
      4'd8:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd10: begin p = 64'(x) * 64'(y); e.res = p[31:0]; e.lat = 33; end
      default: e.ill = 1;
    endcase
    if (o >= 4'd5 && o <= 4'd7) e.lat = 1 + sh;
    e.z = (e.res == 0);
    return e;
  endfunction

  // Present a request and hold it until accepted.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int g;
    @(negedge clk);
    in_valid = 1; op = o; a = x; b = y;
    g = 0;
    while (!in_ready && g < 500) begin @(negedge clk); g++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e = model(o, x, y);
      e.acc = cyc + 1;
      if (chk_b2b) begin chk("b2b_accept", 64'(e.acc), 64'(hs_cyc + 1)); chk_b2b = 0; end
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 3000) begin @(negedge clk); g++; end
    chk("drain", 64'(q.size()), 0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q[0];
          if (!seen) begin
            chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            seen = 1;
          end
          chk("result", 64'(result), 64'(e.res));
          chk("zero", 64'(zero), 64'(e.z));
          chk("illegal", 64'(illegal), 64'(e.ill));
          chk("busy_in_done", 64'(busy), 1);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
            hs_cyc = cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    bad++;
    $display("FAIL watchdog cycles=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset = 0; in_valid = 0; a = 0; b = 0; op = 0;
    rand_rdy = 0; rdy_dir = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_zero", 64'(zero), 1);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_illegal", 64'(illegal), 0);
    reset = 1;

    // Single-cycle ops and flags
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    issue(OP_SLT, 32'h8000_0000, 32'd1);
    issue(OP_SLTU, 32'h8000_0000, 32'd1);
    issue(OP_SUB, 32'd5, 32'd7);
    idle(); drain();

    // Shifts: long iterative and zero-amount
    issue(OP_SRA, 32'h8000_0000, 32'd31);
    issue(OP_SRA, 32'h8765_4321, 32'hFFFF_FFE0);
    issue(OP_SLL, 32'h0000_0001, 32'd31);
    issue(OP_SRL, 32'h8000_0000, 32'd1);
    idle(); drain();

    // MUL with a competing request held during CALC
    issue(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    repeat (5) begin
      @(negedge clk);
      in_valid = 1; op = OP_ADD; a = 32'd7; b = 32'd8;
      chk("calc_in_ready", 64'(in_ready), 0);
      chk("calc_busy", 64'(busy), 1);
      chk("calc_no_accept", 64'(q.size()), 1);
    end
    issue(OP_ADD, 32'd7, 32'd8);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(); drain();

    // Backpressure: hold DONE for 10 cycles, then release and follow up
    @(posedge clk); #2 rdy_dir = 0;
    issue(OP_XOR, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    idle();
    begin
      int g;
      g = 0;
      while (!out_valid && g < 100) begin @(negedge clk); g++; end
      chk("bp_valid_seen", 64'(out_valid), 1);
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_valid_held", 64'(out_valid), 1);
    end
    @(posedge clk); #2 rdy_dir = 1;
    chk_b2b = 1;
    issue(OP_OR, 32'h1234_0000, 32'h0000_5678);
    idle(); drain();

    // Illegal opcode
    issue(4'd13, 32'h1111_2222, 32'h3333_4444);
    issue(4'd15, 32'h0, 32'h0);
    idle(); drain();

    // Reset pulsed mid-MUL discards the operation
    issue(OP_MUL, 32'h0000_1234, 32'h0000_5678);
    idle();
    repeat (8) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    chk("midrst_result", 64'(result), 0);
    chk("midrst_zero", 64'(zero), 1);
    q.delete(); seen = 0;
    @(posedge clk); @(posedge clk); #2 reset = 1;
    repeat (40) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(out_valid), 0);
    end
    issue(OP_ADD, 32'd2, 32'd3);
    idle(); drain();

    // Randomized traffic with random output backpressure
    @(posedge clk); #2 rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      if (i % 3 == 0) ro = 4'($urandom_range(5, 10));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ;
      endcase
      issue(ro, ra, rb);
    end
    idle(); drain();
    @(posedge clk); #2 rand_rdy = 0;

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the nano_rv32i execute stage, successor to the fixed 32-bit combinational ALU. Operands and opcode enter through a valid/ready handshake; single-cycle ops complete in one cycle, shifts and multiply run on an iterative datapath. The registered result is held under output backpressure until consumed. Driven by the existing driver/monitor testbench style on one clock.

## Interface
- WIDTH, 32, operand/result width in bits (≥8, power of two)
- SHIFT_ITER, 1, 1 = shifts iterate one bit per cycle; 0 = single-cycle barrel shift
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (reset == 0 clears all state immediately)
- in_valid_i  in  1  request valid
- in_ready_o  out  1  block can accept a request
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- alu_op_i  in  4  operation code (alu_pkg::alu_op_e)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  result
- zero_o  out  1  1 when result_o == 0
- illegal_o  out  1  opcode was not a defined operation
- busy_o  out  1  request accepted and not yet delivered

## Operation
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10; 11–15 illegal.
- ADD/SUB wrap modulo 2^WIDTH. SLT signed compare, SLTU unsigned; result is 1 or 0 zero-extended.
- Shifts use b_i[SHW-1:0]; upper bits ignored. SRA replicates sign bit.
- MUL: low WIDTH bits of product, shift-add, one partial product per cycle, WIDTH iterations.
- Illegal opcode: result 0, zero_o=1, illegal_o=1, single-cycle latency.
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready_o=1. Accept on in_valid_i & in_ready_o; latch a_i, b_i, op. Single-cycle op (or shift with SHIFT_ITER=0, or shift amount 0) → DONE; shift/MUL otherwise → CALC, loading counter with shamt or WIDTH.
  - CALC: one step per cycle, counter decrements; on last step → DONE.
  - DONE: out_valid_o=1; result_o, zero_o, illegal_o stable. On out_valid_o & out_ready_i → IDLE.
- in_ready_o = (state == IDLE); requests while busy are not accepted and must be held by the producer. Inputs are sampled only at accept.
- busy_o = (state != IDLE).
- zero_o and illegal_o are registered alongside result_o.

## Timing
- Reset values: state IDLE, out_valid_o 0, result_o 0, zero_o 1, illegal_o 0, busy_o 0, in_ready_o 1, counter 0.
- Latency (accept edge to first cycle out_valid_o high): 1 cycle for single-cycle ops; 1+shamt for iterative shifts; 1+WIDTH for MUL.
- out_ready_i held 1: next request accepted the cycle after the output handshake; minimum 2 cycles per op.
- out_ready_i low: DONE held indefinitely, outputs unchanged.
- Reset asserted mid-CALC or DONE: operation discarded, no result emitted, outputs at reset values immediately.
- Counter width $clog2(WIDTH)+1; no wrap at shamt = WIDTH-1 or MUL count = WIDTH.

## Structure
- Package alu_pkg: alu_op_e (4-bit enum), alu_state_e, OP_LAST_LEGAL constant; shared with the testbench interface and scoreboard.
- Sub-module alu_iter_unit: shift/multiply datapath plus step counter, start/done handshake to the FSM; alu_mc keeps the FSM, single-cycle logic and output registers.
- Testbench interface keeps the driver (posedge) / monitor (negedge) clocking-block and modport split, extended with the handshake signals.

## Test plan
- Reset: hold reset=0 for 3 cycles → out_valid_o=0, result_o=0, zero_o=1, in_ready_o=1.
- ADD 0xFFFF_FFFF + 1, out_ready_i=1 → out_valid_o exactly 1 cycle after accept, result 0, zero_o=1; SLT 0x8000_0000 vs 1 → 1; SLTU same operands → 0.
- SRA 0x8000_0000 by 31 (SHIFT_ITER=1) → out_valid_o 32 cycles after accept, result 0xFFFF_FFFF; shift by 0 → latency 1, result equals a_i.
- MUL 0x0001_0003 × 0x0002_0005 → latency 33, result 0x000B_000F; in_valid_i held high during CALC is not accepted.
- Backpressure: out_ready_i=0 for 10 cycles in DONE → outputs stable, in_ready_o=0; raise out_ready_i → one handshake, next request accepted following cycle.
- Opcode 13 → illegal_o=1, result 0; reset pulsed mid-MUL → no out_valid_o, next ADD 2+3 returns 5.
